// File: rtl/mult_pkg.sv
// Shared types and helpers for the iterative radix-8 Booth multiplier.
package mult_pkg;

    // funct3[1:0] encoding of the four RV32M multiply variants
    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } mult_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_PREP = 2'b01,
        ST_ITER = 2'b10,
        ST_DONE = 2'b11
    } mult_state_e;

    // sa: operand A is signed, sb: operand B is signed
    typedef struct packed {
        logic sa;
        logic sb;
    } sign_mode_t;

    // Number of radix-8 digits needed to cover a (length+2)-bit multiplier
    function automatic int ndig(input int length);
        return (length + 4) / 3;
    endfunction

    function automatic sign_mode_t sign_mode_of(input mult_op_e op);
        sign_mode_t m;
        m.sa = (op != OP_MULHU);
        m.sb = (op == OP_MUL) || (op == OP_MULH);
        return m;
    endfunction

endpackage

// File: rtl/booth_r8_slice.sv
// One radix-8 Booth digit: recodes a 4-bit window and selects the signed
// multiple of A (0, +-A, +-2A, +-3A, +-4A) as a (LENGTH+4)-bit partial product.
module booth_r8_slice #(
    parameter int LENGTH = 32
) (
    input  logic [3:0]        i_window,
    input  logic [LENGTH+1:0] i_a_ext,
    input  logic [LENGTH+3:0] i_a3_ext,
    output logic [LENGTH+3:0] o_pp
);

    logic [LENGTH+3:0] w_a1;
    logic [LENGTH+3:0] w_a2;
    logic [LENGTH+3:0] w_a4;
    logic [LENGTH+3:0] w_mag;
    logic              w_neg;

    assign w_a1 = {{2{i_a_ext[LENGTH+1]}}, i_a_ext};
    assign w_a2 = w_a1 << 1;
    assign w_a4 = w_a1 << 2;

    // Digit = -4*w[3] + 2*w[2] + w[1] + w[0]; pick magnitude and sign
    always_comb begin
        w_mag = '0;
        w_neg = 1'b0;
        case (i_window)
            4'b0001, 4'b0010: w_mag = w_a1;
            4'b0011, 4'b0100: w_mag = w_a2;
            4'b0101, 4'b0110: w_mag = i_a3_ext;
            4'b0111:          w_mag = w_a4;
            4'b1000:          begin w_mag = w_a4;     w_neg = 1'b1; end
            4'b1001, 4'b1010: begin w_mag = i_a3_ext; w_neg = 1'b1; end
            4'b1011, 4'b1100: begin w_mag = w_a2;     w_neg = 1'b1; end
            4'b1101, 4'b1110: begin w_mag = w_a1;     w_neg = 1'b1; end
            default:          w_mag = '0;
        endcase
    end

    assign o_pp = w_neg ? (-w_mag) : w_mag;

endmodule

// File: rtl/mult_radix8_seq.sv
// Iterative radix-8 Booth multiplier for RV32M. Digits are consumed from the
// most significant group down so the accumulator only ever needs a constant
// left shift of 3*DPC per cycle. The last full product is cached so a
// MULH/MUL pair on identical operands completes in one cycle.
module mult_radix8_seq
    import mult_pkg::*;
#(
    parameter int LENGTH = 32,
    parameter int DPC    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LENGTH-1:0] oper_a,
    input  logic [LENGTH-1:0] oper_b,
    input  logic              enable_mult,
    input  logic [1:0]        fuct3,
    input  logic              mult_kill,
    output logic              mult_ready,
    output logic              mult_busy,
    output logic [LENGTH-1:0] mult_o,
    output logic              mult_finish
);

    localparam int NDIG  = ndig(LENGTH);
    localparam int NSTEP = NDIG / DPC;
    localparam int BW    = 3 * NDIG;
    localparam int PW    = 2 * LENGTH;
    localparam int AW    = LENGTH + 2;
    localparam int XW    = LENGTH + 4;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    mult_state_e       r_state, w_state_next;
    mult_op_e          w_op, r_op;
    sign_mode_t        w_mode, r_mode;
    logic [LENGTH-1:0] r_a, r_b;
    logic [AW-1:0]     w_a_ext, r_a_ext;
    logic [XW-1:0]     r_a3;
    logic [BW-1:0]     w_b_ext;
    logic [BW:0]       r_b_sh;
    logic [CW-1:0]     r_cnt;
    logic [PW-1:0]     r_acc, w_acc_next, w_pp_sum;
    logic [XW-1:0]     w_pp     [DPC];
    logic [PW-1:0]     w_pp_ext [DPC];
    logic [XW-1:0]     w_a_ext4;

    logic              r_c_valid;
    logic [LENGTH-1:0] r_c_a, r_c_b;
    sign_mode_t        r_c_mode;
    logic [PW-1:0]     r_c_p;

    logic              r_ready, r_busy, r_finish;
    logic [LENGTH-1:0] r_out;
    logic              w_accept, w_hit, w_last;

    function automatic logic [LENGTH-1:0] pick(input logic [PW-1:0] p, input mult_op_e op);
        return (op == OP_MUL) ? p[LENGTH-1:0] : p[PW-1:LENGTH];
    endfunction

    assign w_op     = mult_op_e'(fuct3);
    assign w_mode   = sign_mode_of(w_op);
    assign w_a_ext  = w_mode.sa ? {{2{oper_a[LENGTH-1]}}, oper_a} : {2'b00, oper_a};
    assign w_b_ext  = w_mode.sb ? {{(BW-LENGTH){oper_b[LENGTH-1]}}, oper_b}
                                : {{(BW-LENGTH){1'b0}}, oper_b};
    // Low half is sign-mode independent, so MUL hits on any cached mode
    assign w_hit    = r_c_valid && (oper_a == r_c_a) && (oper_b == r_c_b) &&
                      ((w_op == OP_MUL) || (w_mode == r_c_mode));
    assign w_accept = enable_mult && r_ready && !mult_kill;
    assign w_last   = (r_cnt == CW'(NSTEP - 1));
    assign w_a_ext4 = {{2{r_a_ext[AW-1]}}, r_a_ext};

    // The top DPC windows of the shift register form the current digit group
    genvar gi;
    generate
        for (gi = 0; gi < DPC; gi++) begin : g_slice
            booth_r8_slice #(.LENGTH(LENGTH)) u_slice (
                .i_window (r_b_sh[3*(NDIG-DPC+gi) +: 4]),
                .i_a_ext  (r_a_ext),
                .i_a3_ext (r_a3),
                .o_pp     (w_pp[gi])
            );
            assign w_pp_ext[gi] = {{(PW-XW){w_pp[gi][XW-1]}}, w_pp[gi]} << (3*gi);
        end
    endgenerate

    // Sum the weighted partial products of this cycle's digit group
    always_comb begin
        w_pp_sum = '0;
        for (int j = 0; j < DPC; j++) begin
            w_pp_sum = w_pp_sum + w_pp_ext[j];
        end
    end

    assign w_acc_next = (r_acc << (3*DPC)) + w_pp_sum;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state logic; kill overrides everything
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = w_hit ? ST_DONE : ST_PREP;
            ST_PREP: w_state_next = ST_ITER;
            ST_ITER: if (w_last) w_state_next = ST_DONE;
            ST_DONE: begin
                if (w_accept) w_state_next = w_hit ? ST_DONE : ST_PREP;
                else          w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (mult_kill) w_state_next = ST_IDLE;
    end

    // Operand capture, iteration datapath and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_MUL;
            r_mode   <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_a_ext  <= '0;
            r_a3     <= '0;
            r_b_sh   <= '0;
            r_cnt    <= '0;
            r_acc    <= '0;
            r_ready  <= 1'b0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
            r_out    <= '0;
        end else begin
            r_ready  <= (w_state_next == ST_IDLE) || (w_state_next == ST_DONE);
            r_busy   <= (w_state_next == ST_PREP) || (w_state_next == ST_ITER);
            r_finish <= (w_state_next == ST_DONE);
            if (w_accept) begin
                r_op    <= w_op;
                r_mode  <= w_mode;
                r_a     <= oper_a;
                r_b     <= oper_b;
                r_a_ext <= w_a_ext;
                r_b_sh  <= {w_b_ext, 1'b0};
            end
            if (r_state == ST_PREP) begin
                r_a3  <= w_a_ext4 + (w_a_ext4 << 1);
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_state == ST_ITER) begin
                r_acc  <= w_acc_next;
                r_b_sh <= r_b_sh << (3*DPC);
                r_cnt  <= r_cnt + 1'b1;
            end
            // On a hit the result comes from the cache with the new op's half
            if (w_state_next == ST_DONE) begin
                r_out <= (r_state == ST_ITER) ? pick(w_acc_next, r_op) : pick(r_c_p, w_op);
            end
        end
    end

    // Product cache: filled only by a completed iteration, dropped on kill
    always_ff @(posedge clk) begin
        if (rst || mult_kill) begin
            r_c_valid <= 1'b0;
            if (rst) begin
                r_c_a    <= '0;
                r_c_b    <= '0;
                r_c_mode <= '0;
                r_c_p    <= '0;
            end
        end else if ((r_state == ST_ITER) && w_last) begin
            r_c_valid <= 1'b1;
            r_c_a     <= r_a;
            r_c_b     <= r_b;
            r_c_mode  <= r_mode;
            r_c_p     <= w_acc_next;
        end
    end

    assign mult_ready  = r_ready;
    assign mult_busy   = r_busy;
    assign mult_finish = r_finish;
    assign mult_o      = r_out;

endmodule

// File: tb/tb_mult_radix8_seq.sv
// Directed bench for mult_radix8_seq: a DPC=1 instance for exact-latency,
// cache and kill vectors, and a DPC=4 instance for a modelled operand sweep.
module tb_mult_radix8_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a1 = '0, b1 = '0, a4 = '0, b4 = '0;
    logic [1:0]  f1 = '0, f4 = '0;
    logic        en1 = 1'b0, en4 = 1'b0, kill1 = 1'b0, kill4 = 1'b0;
    logic        ready1, busy1, fin1, ready4, busy4, fin4;
    logic [31:0] o1, o4;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    mult_radix8_seq #(.LENGTH(32), .DPC(1)) u_dut1 (
        .clk(clk), .rst(rst), .oper_a(a1), .oper_b(b1), .enable_mult(en1),
        .fuct3(f1), .mult_kill(kill1), .mult_ready(ready1), .mult_busy(busy1),
        .mult_o(o1), .mult_finish(fin1)
    );

    mult_radix8_seq #(.LENGTH(32), .DPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .oper_a(a4), .oper_b(b4), .enable_mult(en4),
        .fuct3(f4), .mult_kill(kill4), .mult_ready(ready4), .mult_busy(busy4),
        .mult_o(o4), .mult_finish(fin4)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Reference: extend per sign mode, multiply mod 2^64, select half
    function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ae, be, p;
        ae = (op != 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
        be = (op <= 2'b01) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ae * be;
        return (op == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Issue one op on instance sel (0: DPC=1, 1: DPC=4); lat counts cycles after accept
    task automatic run_op(input int sel, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res, output int lat);
        @(negedge clk);
        if (sel == 0) begin a1 = a; b1 = b; f1 = op; en1 = 1'b1; end
        else          begin a4 = a; b4 = b; f4 = op; en4 = 1'b1; end
        @(posedge clk);
        lat = -1;
        res = '0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            en1 = 1'b0;
            en4 = 1'b0;
            if ((sel == 0) ? fin1 : fin4) begin
                lat = i;
                res = (sel == 0) ? o1 : o4;
                break;
            end
        end
        $display("op=%0d a=%08h b=%08h -> %08h lat=%0d (dpc%0d)", op, a, b, res, lat, (sel == 0) ? 1 : 4);
    endtask

    // Directed vectors for the DPC=1 instance
    typedef struct {
        string       tag;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    vec_t vecs[9] = '{
        '{"mul_neg1x2",      2'b00, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 14},
        '{"mulhu_max",       2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 14},
        '{"mulh_max_miss",   2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 14},
        '{"mulhsu_max",      2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 14},
        '{"mulh_min",        2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 14},
        '{"mul_min_hit",     2'b00, 32'h80000000, 32'h80000000, 32'h00000000, 1},
        '{"mulhsu_min",      2'b10, 32'h80000000, 32'h80000000, 32'hC0000000, 14},
        '{"mul_7xm3",        2'b00, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, 14},
        '{"mulhu_2p31x2",    2'b11, 32'h80000000, 32'h00000002, 32'h00000001, 14}
    };

    // Bench-side cache model for the sweep's expected latency
    logic        m_valid = 1'b0;
    logic [31:0] m_a = '0, m_b = '0;
    logic [1:0]  m_mode = '0;

    function automatic logic [1:0] mode_of(input logic [1:0] op);
        return {op != 2'b11, op <= 2'b01};
    endfunction

    function automatic logic [31:0] pick_val(input int r);
        case (r)
            0:       return 32'h00000000;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] res, a, b, exp;
        logic [1:0]  op;
        int          lat, nfin, first_lat, exp_lat;
        logic        seen, hit;

        // Reset state
        repeat (3) @(negedge clk);
        check_eq("rst_o",      o1,     32'h0);
        check_eq("rst_finish", 32'(fin1),   32'h0);
        check_eq("rst_ready",  32'(ready1), 32'h0);
        check_eq("rst_busy",   32'(busy1),  32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("ready_idle", 32'(ready1), 32'h1);

        foreach (vecs[i]) begin
            run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            check_eq({vecs[i].tag, "_val"}, res, vecs[i].exp);
            check_eq({vecs[i].tag, "_lat"}, 32'(lat), 32'(vecs[i].lat));
        end

        // Kill: cache X under MULH, kill a MULHU X at T+6, then MULH X must miss
        run_op(0, 2'b01, 32'h00010000, 32'h00010000, res, lat);
        check_eq("kill_pre_val", res, 32'h1);
        check_eq("kill_pre_lat", 32'(lat), 32'd14);
        @(negedge clk);
        a1 = 32'h00010000; b1 = 32'h00010000; f1 = 2'b11; en1 = 1'b1;
        @(posedge clk);
        seen = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            en1 = 1'b0;
            if (fin1) seen = 1'b1;
            if (i == 6) kill1 = 1'b1;
        end
        @(negedge clk);
        kill1 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (fin1) seen = 1'b1;
            @(negedge clk);
        end
        $display("kill at T+6: finish_seen=%0d o=%08h", seen, o1);
        check_eq("kill_nofinish", 32'(seen), 32'h0);
        check_eq("kill_hold_o",   o1, 32'h1);
        check_eq("kill_ready",    32'(ready1), 32'h1);
        run_op(0, 2'b01, 32'h00010000, 32'h00010000, res, lat);
        check_eq("kill_inval_val", res, 32'h1);
        check_eq("kill_inval_lat", 32'(lat), 32'd14);
        run_op(0, 2'b11, 32'h00010000, 32'h00010000, res, lat);
        check_eq("kill_redo_val", res, 32'h1);
        check_eq("kill_redo_lat", 32'(lat), 32'd14);

        // DPC=4 sweep against the reference model
        for (int n = 0; n < 2000; n++) begin
            a   = pick_val($urandom_range(0, 7));
            b   = pick_val($urandom_range(0, 7));
            op  = 2'($urandom_range(0, 3));
            exp = ref_mul(op, a, b);
            hit = m_valid && (a == m_a) && (b == m_b) && ((op == 2'b00) || (mode_of(op) == m_mode));
            exp_lat = hit ? 1 : 5;
            run_op(1, op, a, b, res, lat);
            check_eq("sweep_val", res, exp);
            check_eq("sweep_lat", 32'(lat), 32'(exp_lat));
            if (!hit) begin
                m_valid = 1'b1; m_a = a; m_b = b; m_mode = mode_of(op);
            end
        end

        // Enable while busy must not start a second operation
        @(negedge clk);
        a4 = 32'h12345678; b4 = 32'h9ABCDEF1; f4 = 2'b10; en4 = 1'b1;
        exp = ref_mul(2'b10, 32'h12345678, 32'h9ABCDEF1);
        @(posedge clk);
        nfin = 0;
        first_lat = -1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            en4 = (i == 2);
            if (i == 1) begin
                check_eq("busy_t1",  32'(busy4),  32'h1);
                check_eq("ready_t1", 32'(ready4), 32'h0);
            end
            if (fin4) begin
                nfin++;
                if (first_lat < 0) begin
                    first_lat = i;
                    check_eq("busy_ign_val", o4, exp);
                end
            end
        end
        en4 = 1'b0;
        $display("enable while busy: finishes=%0d first_lat=%0d o=%08h", nfin, first_lat, o4);
        check_eq("busy_ign_count", 32'(nfin), 32'd1);
        check_eq("busy_ign_lat",   32'(first_lat), 32'd5);

        // Reset mid-operation clears mult_o and suppresses finish
        @(negedge clk);
        a1 = 32'h00000003; b1 = 32'h00000005; f1 = 2'b00; en1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        en1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        $display("reset mid-op: o=%08h busy=%0d finish=%0d", o1, busy1, fin1);
        check_eq("rstmid_o",      o1, 32'h0);
        check_eq("rstmid_busy",   32'(busy1), 32'h0);
        check_eq("rstmid_finish", 32'(fin1),  32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("rstmid_ready",  32'(ready1), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
